// File: rtl/resp_tx_pkg.sv
// Shared definitions for the response serialiser: descriptor layout, field encodings,
// DSC bit positions and the frame state encoding.
package resp_tx_pkg;

   localparam int         MREQ_NBIT    = 21;
   localparam logic [7:0] CMD_TX_START = 8'hA5;

   localparam int DSC_WSZ  = 0;
   localparam int DSC_PCRC = 2;

   localparam logic [3:0] MREQ_WFMT_32S0 = 4'd0;
   localparam logic [3:0] MREQ_WFMT_16S0 = 4'd1;
   localparam logic [3:0] MREQ_WFMT_16S1 = 4'd2;
   localparam logic [3:0] MREQ_WFMT_8S0  = 4'd3;
   localparam logic [3:0] MREQ_WFMT_8S1  = 4'd4;
   localparam logic [3:0] MREQ_WFMT_8S2  = 4'd5;
   localparam logic [3:0] MREQ_WFMT_8S3  = 4'd6;

   typedef struct packed {
      logic [7:0] wcnt;
      logic [3:0] wfmt;
      logic       wr;
      logic [7:0] tag;
   } mreq_t;

   typedef enum logic [2:0] {
      IDLE, H_START, H_DSC, H_TAG, H_WCNT, H_CRC, DATA, P_CRC
   } state_t;

   function automatic mreq_t unpack_mreq(input logic [MREQ_NBIT-1:0] raw);
      return mreq_t'(raw);
   endfunction

   // Writes and unknown formats carry no payload, so they collapse to size code 0.
   function automatic logic [1:0] wsz_of(input logic wr, input logic [3:0] wfmt);
      if (wr) return 2'd0;
      case (wfmt)
         MREQ_WFMT_32S0:                                            return 2'd3;
         MREQ_WFMT_16S0, MREQ_WFMT_16S1:                            return 2'd2;
         MREQ_WFMT_8S0, MREQ_WFMT_8S1, MREQ_WFMT_8S2, MREQ_WFMT_8S3: return 2'd1;
         default:                                                   return 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/resp_tx_crc8.sv
// Combinational CRC-8 step (polynomial x^8+x^2+x+1, MSB first): folds one byte into crc_in.
module resp_tx_crc8 (
   input  logic [7:0] crc_in,
   input  logic [7:0] data,
   output logic [7:0] crc_out
);

   always_comb begin
      logic [7:0] c;
      c = crc_in ^ data;
      for (int i = 0; i < 8; i++) begin
         c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
      end
      crc_out = c;
   end

endmodule

// File: rtl/resp_tx.sv
// Response-stream serialiser: 5-byte header, optional little-endian read payload and
// optional payload CRC, emitted one byte per downstream acknowledge.
module resp_tx
   import resp_tx_pkg::*;
#(
   parameter logic [7:0] START_BYTE  = CMD_TX_START,
   parameter int         DATA_NBIT   = 32,
   parameter bit         PAYLOAD_CRC = 1'b1
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   output logic [7:0]           o_tx_data,
   output logic                 o_tx_valid,
   input  logic                 i_tx_ready,
   input  logic                 i_mreq_valid,
   output logic                 o_mreq_ready,
   input  logic [MREQ_NBIT-1:0] i_mreq,
   input  logic [DATA_NBIT-1:0] i_rdata,
   input  logic                 i_rdata_valid,
   output logic                 o_rdata_ready
);

   state_t      state, state_next;
   mreq_t       req;
   logic [7:0]  tag, wcnt, hcrc, pcrc, hcrc_next, pcrc_next;
   logic [7:0]  dsc, data_byte, tx_data_raw, word_cnt;
   logic [1:0]  wsz, byte_cnt, byte_last;
   logic [31:0] rdata_ext;
   logic        tx_valid_raw, tx_ack, last_byte, last_word, frame_end, word_end;

   assign req       = unpack_mreq(i_mreq);
   // Narrow words are zero-extended so byte lanes beyond DATA_NBIT read as 0x00.
   assign rdata_ext = 32'(i_rdata);
   assign data_byte = rdata_ext[{byte_cnt, 3'b000} +: 8];
   assign byte_last = (wsz == 2'd3) ? 2'd3 : (wsz == 2'd2) ? 2'd1 : 2'd0;
   assign last_byte = (byte_cnt == byte_last);
   assign last_word = (word_cnt == wcnt);

   always_comb begin
      dsc                = '0;
      dsc[DSC_WSZ +: 2]  = wsz;
      dsc[DSC_PCRC]      = PAYLOAD_CRC && (wsz != 2'd0);
   end

   resp_tx_crc8 u_hdr_crc (.crc_in(hcrc), .data(tx_data_raw), .crc_out(hcrc_next));
   resp_tx_crc8 u_pay_crc (.crc_in(pcrc), .data(tx_data_raw), .crc_out(pcrc_next));

   // Reset masks the handshake outputs at once so an aborted frame never completes.
   assign o_tx_valid    = tx_valid_raw & ~i_rst;
   assign o_tx_data     = i_rst ? 8'h00 : tx_data_raw;
   assign tx_ack        = o_tx_valid & i_tx_ready;
   assign o_mreq_ready  = tx_ack & frame_end;
   assign o_rdata_ready = tx_ack & word_end;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state    <= IDLE;
         tag      <= '0;
         wcnt     <= '0;
         wsz      <= '0;
         hcrc     <= '0;
         pcrc     <= '0;
         byte_cnt <= '0;
         word_cnt <= '0;
      end else begin
         state <= state_next;
         if (state == IDLE && i_mreq_valid) begin
            tag  <= req.tag;
            wcnt <= req.wcnt;
            wsz  <= wsz_of(req.wr, req.wfmt);
            hcrc <= '0;
         end
         if (tx_ack) begin
            case (state)
               H_START, H_DSC, H_TAG, H_WCNT: hcrc <= hcrc_next;
               H_CRC: begin
                  pcrc     <= '0;
                  byte_cnt <= '0;
                  word_cnt <= '0;
               end
               DATA: begin
                  pcrc <= pcrc_next;
                  if (last_byte) begin
                     byte_cnt <= '0;
                     word_cnt <= word_cnt + 8'd1;
                  end else begin
                     byte_cnt <= byte_cnt + 2'd1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (i_mreq_valid) state_next = H_START;
         H_START: if (tx_ack) state_next = H_DSC;
         H_DSC:   if (tx_ack) state_next = H_TAG;
         H_TAG:   if (tx_ack) state_next = H_WCNT;
         H_WCNT:  if (tx_ack) state_next = H_CRC;
         H_CRC:   if (tx_ack) state_next = (wsz == 2'd0) ? IDLE : DATA;
         DATA:    if (tx_ack && last_byte && last_word) state_next = PAYLOAD_CRC ? P_CRC : IDLE;
         P_CRC:   if (tx_ack) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      tx_data_raw  = '0;
      tx_valid_raw = 1'b0;
      frame_end    = 1'b0;
      word_end     = 1'b0;
      case (state)
         H_START: begin tx_data_raw = START_BYTE; tx_valid_raw = 1'b1; end
         H_DSC:   begin tx_data_raw = dsc;        tx_valid_raw = 1'b1; end
         H_TAG:   begin tx_data_raw = tag;        tx_valid_raw = 1'b1; end
         H_WCNT:  begin tx_data_raw = wcnt;       tx_valid_raw = 1'b1; end
         H_CRC: begin
            tx_data_raw  = hcrc;
            tx_valid_raw = 1'b1;
            frame_end    = (wsz == 2'd0);
         end
         DATA: begin
            tx_data_raw  = data_byte;
            tx_valid_raw = i_rdata_valid;
            word_end     = last_byte;
            frame_end    = last_byte && last_word && (PAYLOAD_CRC == 1'b0);
         end
         P_CRC: begin
            tx_data_raw  = pcrc;
            tx_valid_raw = 1'b1;
            frame_end    = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_resp_tx.sv
// Self-checking bench for resp_tx: table vectors, randomized stalls against a frame-level
// reference model, mid-frame reset, and a 16-bit / no-payload-CRC variant.
module tb_resp_tx;
   import resp_tx_pkg::*;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [7:0]           tx_data;
   logic                 tx_valid, tx_ready, mreq_valid, mreq_ready, rdata_valid, rdata_ready;
   logic [MREQ_NBIT-1:0] mreq;
   logic [31:0]          rdata;

   logic [7:0]           tx_data16;
   logic                 tx_valid16, tx_ready16, mreq_valid16, mreq_ready16;
   logic                 rdata_valid16, rdata_ready16;
   logic [MREQ_NBIT-1:0] mreq16;
   logic [15:0]          rdata16;

   int          tests = 0;
   int          fails = 0;
   logic [7:0]  got_q[$];
   logic [7:0]  exp_q[$];
   logic [31:0] words[$];
   int          exp_words, mreq_pulses, rdy_pulses;

   always #5 clk = ~clk;

   resp_tx dut (
      .i_clk(clk), .i_rst(rst), .o_tx_data(tx_data), .o_tx_valid(tx_valid),
      .i_tx_ready(tx_ready), .i_mreq_valid(mreq_valid), .o_mreq_ready(mreq_ready),
      .i_mreq(mreq), .i_rdata(rdata), .i_rdata_valid(rdata_valid), .o_rdata_ready(rdata_ready)
   );

   resp_tx #(.DATA_NBIT(16), .PAYLOAD_CRC(1'b0)) dut16 (
      .i_clk(clk), .i_rst(rst), .o_tx_data(tx_data16), .o_tx_valid(tx_valid16),
      .i_tx_ready(tx_ready16), .i_mreq_valid(mreq_valid16), .o_mreq_ready(mreq_ready16),
      .i_mreq(mreq16), .i_rdata(rdata16), .i_rdata_valid(rdata_valid16),
      .o_rdata_ready(rdata_ready16)
   );

   typedef struct {
      logic [MREQ_NBIT-1:0] m;
      logic [3:0][31:0]     w;
      int                   len;
      logic [7:0]           dsc;
      int                   rdy;
   } vec_t;

   function automatic logic [MREQ_NBIT-1:0] mk_mreq(input logic [7:0] tag, input logic wr,
                                                    input logic [3:0] wfmt, input logic [7:0] wcnt);
      return {wcnt, wfmt, wr, tag};
   endfunction

   // Polynomial long division of (crc ^ byte) * x^8 by 0x107.
   function automatic logic [7:0] crc8_ref(input logic [7:0] c, input logic [7:0] d);
      logic [15:0] x;
      x = {c ^ d, 8'h00};
      for (int i = 15; i >= 8; i--)
         if (x[i]) x = x ^ (16'h0107 << (i - 8));
      return x[7:0];
   endfunction

   function automatic void build_frame(input logic [MREQ_NBIT-1:0] m, input int nbit, input bit pcrc);
      int         bpw, wszv;
      logic [7:0] h, p, b, wc;
      logic [7:0] hdr[4];
      wc  = m[20:13];
      bpw = 0;
      if (!m[8]) begin
         if (m[12:9] == 4'd0) bpw = 4;
         else if (m[12:9] == 4'd1 || m[12:9] == 4'd2) bpw = 2;
         else if (m[12:9] >= 4'd3 && m[12:9] <= 4'd6) bpw = 1;
      end
      wszv   = (bpw == 0) ? 0 : $clog2(bpw) + 1;
      hdr[0] = 8'hA5;
      hdr[1] = 8'(wszv + ((pcrc && bpw != 0) ? 4 : 0));
      hdr[2] = m[7:0];
      hdr[3] = wc;
      exp_q.delete();
      h = 8'h00;
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(hdr[i]);
         h = crc8_ref(h, hdr[i]);
      end
      exp_q.push_back(h);
      exp_words = (bpw == 0) ? 0 : int'(wc) + 1;
      p = 8'h00;
      for (int w = 0; w < exp_words; w++) begin
         for (int k = 0; k < bpw; k++) begin
            b = (k < nbit / 8) ? 8'((words[w] >> (8 * k)) & 32'hFF) : 8'h00;
            exp_q.push_back(b);
            p = crc8_ref(p, b);
         end
      end
      if (pcrc && bpw != 0) exp_q.push_back(p);
   endfunction

   function automatic logic [7:0] got_at(input int i);
      return (i < got_q.size()) ? got_q[i] : 8'hxx;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Drives one request on the 32-bit DUT with random back-pressure and read-data gaps.
   task automatic applyStimulus(input logic [MREQ_NBIT-1:0] m, input int stall_pct, input int gap_pct);
      int         idx;
      bit         done, pend, acked, consumed;
      logic [7:0] pdata;
      idx = 0; done = 0; pend = 0; pdata = 8'h00;
      got_q.delete();
      mreq_pulses = 0;
      rdy_pulses  = 0;
      @(posedge clk); #1;
      mreq        = m;
      mreq_valid  = 1'b1;
      tx_ready    = ($urandom_range(99) >= stall_pct);
      rdata_valid = (words.size() > 0) && ($urandom_range(99) >= gap_pct);
      rdata       = (words.size() > 0) ? words[0] : 32'h0;
      for (int cyc = 0; cyc < 8000 && !done; cyc++) begin
         @(negedge clk);
         if (pend) check("tx_hold", {23'h0, tx_valid, tx_data}, {23'h0, 1'b1, pdata});
         acked    = tx_valid & tx_ready;
         pend     = tx_valid & ~tx_ready;
         pdata    = tx_data;
         consumed = rdata_ready;
         if (acked) got_q.push_back(tx_data);
         if (rdata_ready) rdy_pulses++;
         if (mreq_ready) begin mreq_pulses++; done = 1; end
         @(posedge clk); #1;
         if (consumed) begin idx++; rdata_valid = 1'b0; end
         if (!rdata_valid && idx < words.size() && $urandom_range(99) >= gap_pct) begin
            rdata_valid = 1'b1;
            rdata       = words[idx];
         end
         tx_ready = ($urandom_range(99) >= stall_pct);
         if (done) mreq_valid = 1'b0;
      end
      check("mreq_done", 32'(done), 32'd1);
      rdata_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         if (mreq_ready) mreq_pulses++;
         if (rdata_ready) rdy_pulses++;
      end
   endtask

   task automatic checkOutput(input string name, input logic [MREQ_NBIT-1:0] m, input int nbit,
                              input bit pcrc, input int p_mreq, input int p_rdy);
      build_frame(m, nbit, pcrc);
      check($sformatf("%s_len", name), 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++)
         check($sformatf("%s_byte%0d", name, i), {24'h0, got_at(i)}, {24'h0, exp_q[i]});
      check($sformatf("%s_mreq_pulses", name), 32'(p_mreq), 32'd1);
      check($sformatf("%s_rdata_pulses", name), 32'(p_rdy), 32'(exp_words));
   endtask

   initial begin
      vec_t       vecs[6];
      int         n, p16, r16;
      bit         found, done;
      logic [MREQ_NBIT-1:0] m;

      vecs[0] = '{mk_mreq(8'h12, 1'b1, MREQ_WFMT_32S0, 8'd3), '0, 5, 8'h00, 0};
      vecs[1] = '{mk_mreq(8'h07, 1'b0, MREQ_WFMT_32S0, 8'd0), {96'h0, 32'h44332211}, 10, 8'h07, 1};
      vecs[2] = '{mk_mreq(8'h21, 1'b0, MREQ_WFMT_8S2, 8'd2),
                  {32'h0, 32'h000000CC, 32'h000000BB, 32'h000000AA}, 9, 8'h05, 3};
      vecs[3] = '{mk_mreq(8'h5A, 1'b0, MREQ_WFMT_16S1, 8'd1),
                  {64'h0, 32'h0000ABCD, 32'h00001234}, 10, 8'h06, 2};
      vecs[4] = '{mk_mreq(8'hE3, 1'b0, 4'hF, 8'd3), '0, 5, 8'h00, 0};
      vecs[5] = '{mk_mreq(8'h99, 1'b0, MREQ_WFMT_8S0, 8'd3),
                  {32'hDEADBE04, 32'hDEADBE03, 32'hDEADBE02, 32'hDEADBE01}, 10, 8'h05, 4};

      rst = 1'b1;
      tx_ready = 1'b0; mreq_valid = 1'b0; mreq = '0; rdata = '0; rdata_valid = 1'b0;
      tx_ready16 = 1'b0; mreq_valid16 = 1'b0; mreq16 = '0; rdata16 = '0; rdata_valid16 = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_tx_valid", 32'(tx_valid), 32'd0);
      check("rst_tx_data", 32'(tx_data), 32'd0);
      check("rst_mreq_ready", 32'(mreq_ready), 32'd0);
      check("rst_rdata_ready", 32'(rdata_ready), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      tx_ready = 1'b1;
      repeat (2) begin
         @(negedge clk);
         check("idle_tx_valid", 32'(tx_valid), 32'd0);
      end

      for (int v = 0; v < 6; v++) begin
         words.delete();
         for (int i = 0; i < vecs[v].rdy; i++) words.push_back(vecs[v].w[i]);
         applyStimulus(vecs[v].m, 0, 0);
         check($sformatf("vec%0d_len_table", v), 32'(got_q.size()), 32'(vecs[v].len));
         check($sformatf("vec%0d_start", v), {24'h0, got_at(0)}, 32'h0A5);
         check($sformatf("vec%0d_dsc", v), {24'h0, got_at(1)}, {24'h0, vecs[v].dsc});
         check($sformatf("vec%0d_rdy_table", v), 32'(rdy_pulses), 32'(vecs[v].rdy));
         checkOutput($sformatf("vec%0d", v), vecs[v].m, 32, 1'b1, mreq_pulses, rdy_pulses);
      end

      for (int r = 0; r < 8; r++) begin
         m = mk_mreq(8'($urandom), ($urandom_range(3) == 0), 4'($urandom_range(7)),
                     8'($urandom_range(5)));
         words.delete();
         for (int i = 0; i <= int'(m[20:13]); i++) words.push_back($urandom);
         applyStimulus(m, 40, 30);
         checkOutput($sformatf("rand%0d", r), m, 32, 1'b1, mreq_pulses, rdy_pulses);
      end

      m = mk_mreq(8'hC4, 1'b0, MREQ_WFMT_16S0, 8'd255);
      words.delete();
      for (int i = 0; i < 256; i++) words.push_back($urandom);
      applyStimulus(m, 50, 30);
      checkOutput("long16", m, 32, 1'b1, mreq_pulses, rdy_pulses);

      // Abort a 32S0 read while its third payload byte is on the link.
      n = 0; found = 0;
      @(posedge clk); #1;
      mreq = mk_mreq(8'h07, 1'b0, MREQ_WFMT_32S0, 8'd0);
      mreq_valid = 1'b1; tx_ready = 1'b1; rdata = 32'h44332211; rdata_valid = 1'b1;
      for (int cyc = 0; cyc < 40 && !found; cyc++) begin
         @(negedge clk);
         if (n == 7) found = 1;
         else begin
            if (tx_valid & tx_ready) n++;
            @(posedge clk); #1;
         end
      end
      check("rst_mid_reached", 32'(found), 32'd1);
      check("rst_mid_byte2", 32'(tx_data), 32'h33);
      rst = 1'b1;
      #1;
      check("rst_mid_mreq_ready", 32'(mreq_ready), 32'd0);
      check("rst_mid_rdata_ready", 32'(rdata_ready), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0; mreq_valid = 1'b0; rdata_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_mid_tx_valid", 32'(tx_valid), 32'd0);
         check("rst_mid_no_mreq", 32'(mreq_ready), 32'd0);
      end
      words.delete();
      words.push_back(32'h44332211);
      m = mk_mreq(8'h07, 1'b0, MREQ_WFMT_32S0, 8'd0);
      applyStimulus(m, 0, 0);
      checkOutput("after_rst", m, 32, 1'b1, mreq_pulses, rdy_pulses);

      // 16-bit data path without payload CRC.
      got_q.delete(); p16 = 0; r16 = 0; done = 0;
      words.delete();
      words.push_back(32'h00001234);
      m = mk_mreq(8'h3C, 1'b0, MREQ_WFMT_32S0, 8'd0);
      @(posedge clk); #1;
      mreq16 = m; mreq_valid16 = 1'b1; tx_ready16 = 1'b1; rdata16 = 16'h1234; rdata_valid16 = 1'b1;
      for (int cyc = 0; cyc < 40 && !done; cyc++) begin
         @(negedge clk);
         if (tx_valid16 & tx_ready16) got_q.push_back(tx_data16);
         if (rdata_ready16) r16++;
         if (mreq_ready16) begin p16++; done = 1; end
         @(posedge clk); #1;
         if (r16 > 0) rdata_valid16 = 1'b0;
         if (done) mreq_valid16 = 1'b0;
      end
      repeat (2) begin
         @(negedge clk);
         if (mreq_ready16) p16++;
      end
      check("d16_len", 32'(got_q.size()), 32'd9);
      check("d16_dsc", {24'h0, got_at(1)}, 32'h03);
      check("d16_pad", {24'h0, got_at(8)}, 32'h00);
      checkOutput("d16", m, 16, 1'b0, p16, r16);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
